// File: rtl/mul_result_stage_if.sv
// Bus between the multiplier pipeline and the result stage.
// The master side drives the M/E-stage inputs; the slave side returns the W result and fusion lookup.
interface mul_result_stage_if #(
    parameter int XLEN = 32
);
    logic              StallW;
    logic              FlushW;
    logic              MulValidM;
    logic [2:0]        Funct3M;
    logic              W64M;
    logic [2*XLEN-1:0] ProdM;
    logic [XLEN-1:0]   SrcAM;
    logic [XLEN-1:0]   SrcBM;
    logic [XLEN-1:0]   SrcAE;
    logic [XLEN-1:0]   SrcBE;
    logic [2:0]        Funct3E;
    logic              MulValidE;
    logic [XLEN-1:0]   MulResultW;
    logic              MulValidW;
    logic              FuseHitE;
    logic [XLEN-1:0]   FuseResultE;

    modport master (
        output StallW, FlushW, MulValidM, Funct3M, W64M, ProdM,
               SrcAM, SrcBM, SrcAE, SrcBE, Funct3E, MulValidE,
        input  MulResultW, MulValidW, FuseHitE, FuseResultE
    );

    modport slave (
        input  StallW, FlushW, MulValidM, Funct3M, W64M, ProdM,
               SrcAM, SrcBM, SrcAE, SrcBE, Funct3E, MulValidE,
        output MulResultW, MulValidW, FuseHitE, FuseResultE
    );
endinterface

// File: rtl/mul_result_stage.sv
// Selects the MUL/MULH*/MULW result from the M-stage product into W: 1-cycle latency, StallW holds, FlushW clears.
// Optional one-entry E-stage fusion cache is built only when MUL_RESULT_STAGE_FUSE_EN is defined.
module mul_result_stage #(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    mul_result_stage_if.slave  bus
);

    logic [XLEN-1:0] prod_lo;
    logic [XLEN-1:0] prod_hi;
    logic [XLEN-1:0] w_res;
    logic [XLEN-1:0] sel_res;
    logic [XLEN-1:0] res_q;
    logic            vld_q;
    logic            w_op;
    logic            high_op;

    assign prod_lo = bus.ProdM[XLEN-1:0];
    assign prod_hi = bus.ProdM[2*XLEN-1:XLEN];
    assign high_op = (bus.Funct3M == 3'b001) || (bus.Funct3M == 3'b010) ||
                     (bus.Funct3M == 3'b011);

    // Word ops only exist on RV64; on RV32 W64M is ignored.
    if (XLEN == 64) begin : g_word
        assign w_op  = bus.W64M;
        assign w_res = {{32{prod_lo[31]}}, prod_lo[31:0]};
    end else begin : g_noword
        logic unused_w64;
        assign w_op       = 1'b0;
        assign w_res      = prod_lo;
        assign unused_w64 = bus.W64M;
    end

    always_comb begin
        sel_res = '0;
        if (w_op) begin
            sel_res = w_res;
        end else begin
            case (bus.Funct3M)
                3'b000:                 sel_res = prod_lo;
                3'b001, 3'b010, 3'b011: sel_res = prod_hi;
                default:                sel_res = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_q <= '0;
            vld_q <= 1'b0;
        end else if (bus.FlushW) begin
            res_q <= '0;
            vld_q <= 1'b0;
        end else if (!bus.StallW) begin
            res_q <= sel_res;
            vld_q <= bus.MulValidM;
        end
    end

    assign bus.MulResultW = res_q;
    assign bus.MulValidW  = vld_q;

`ifdef MUL_RESULT_STAGE_FUSE_EN
    logic            c_vld;
    logic [XLEN-1:0] c_a;
    logic [XLEN-1:0] c_b;
    logic [XLEN-1:0] c_lo;
    logic            cache_wr;
    logic            hit;

    // Any high-type op carries the full product; its low half is signedness-independent.
    assign cache_wr = bus.MulValidM & high_op & ~w_op & ~bus.StallW & ~bus.FlushW;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_vld <= 1'b0;
            c_a   <= '0;
            c_b   <= '0;
            c_lo  <= '0;
        end else if (cache_wr) begin
            c_vld <= 1'b1;
            c_a   <= bus.SrcAM;
            c_b   <= bus.SrcBM;
            c_lo  <= prod_lo;
        end
    end

    assign hit = c_vld & bus.MulValidE & (bus.Funct3E == 3'b000) &
                 (bus.SrcAE == c_a) & (bus.SrcBE == c_b);

    assign bus.FuseHitE    = hit;
    assign bus.FuseResultE = hit ? c_lo : '0;
`else
    logic unused_fuse;
    assign unused_fuse = ^{bus.SrcAM, bus.SrcBM, bus.SrcAE, bus.SrcBE,
                           bus.Funct3E, bus.MulValidE, high_op};

    assign bus.FuseHitE    = 1'b0;
    assign bus.FuseResultE = '0;
`endif

endmodule

// File: tb/tb_mul_result_stage.sv
// Randomized bench for mul_result_stage at XLEN=32 and XLEN=64, checked against an arithmetic reference model.
module tb_mul_result_stage;

`ifdef MUL_RESULT_STAGE_FUSE_EN
    localparam bit FUSE = 1'b1;
`else
    localparam bit FUSE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mul_result_stage_if #(.XLEN(32)) if32();
    mul_result_stage_if #(.XLEN(64)) if64();

    mul_result_stage #(.XLEN(32)) dut32 (.clk(clk), .reset_n(reset_n), .bus(if32.slave));
    mul_result_stage #(.XLEN(64)) dut64 (.clk(clk), .reset_n(reset_n), .bus(if64.slave));

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus: control shared by both instances, operands per instance (0: XLEN=32, 1: XLEN=64)
    logic        st, fl, vm, w64, ve;
    logic [2:0]  f3, f3e;
    logic [63:0] am [2];
    logic [63:0] bm [2];
    logic [63:0] ae [2];
    logic [63:0] be [2];

    // Reference model: expected W outputs and the last cached high-type operand pair
    logic [63:0] e_res [2];
    logic        e_vld [2];
    logic        m_cv  [2];
    logic [63:0] m_ca  [2];
    logic [63:0] m_cb  [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] xmask(input int xl, input logic [63:0] v);
        return (xl == 32) ? {32'b0, v[31:0]} : v;
    endfunction

    // True double-width product of the operands, with signedness per Funct3.
    function automatic logic [127:0] ref_prod(input int xl, input logic [2:0] f,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [127:0] sa, sb, ua, ub, p;
        if (xl == 32) begin
            ua = {96'b0, a[31:0]};
            ub = {96'b0, b[31:0]};
            sa = {{96{a[31]}}, a[31:0]};
            sb = {{96{b[31]}}, b[31:0]};
        end else begin
            ua = {64'b0, a};
            ub = {64'b0, b};
            sa = {{64{a[63]}}, a};
            sb = {{64{b[63]}}, b};
        end
        case (f)
            3'b001:  p = sa * sb;
            3'b010:  p = sa * ub;
            default: p = ua * ub;
        endcase
        if (xl == 32) p[127:64] = '0;
        return p;
    endfunction

    function automatic logic [63:0] ref_result(input int xl, input logic [2:0] f, input logic w,
                                               input logic [63:0] a, input logic [63:0] b);
        logic [63:0]  p;
        logic [127:0] full;
        if (xl == 64 && w) begin
            p = {32'b0, a[31:0]} * {32'b0, b[31:0]};
            return {{32{p[31]}}, p[31:0]};
        end
        full = ref_prod(xl, f, a, b) >> xl;
        case (f)
            3'b000:                 return xmask(xl, a * b);
            3'b001, 3'b010, 3'b011: return xmask(xl, full[63:0]);
            default:                return 64'b0;
        endcase
    endfunction

    // Drive inputs, then check the combinational fusion lookup against the model.
    task automatic apply();
        logic [127:0] p;
        logic [63:0]  obs_res, exp_res;
        logic         obs_hit, exp_hit;
        int           xl;
        p = ref_prod(32, f3, am[0], bm[0]);
        if32.StallW = st;  if32.FlushW = fl;  if32.MulValidM = vm;  if32.Funct3M = f3;
        if32.W64M = w64;   if32.ProdM = p[63:0];
        if32.SrcAM = am[0][31:0];  if32.SrcBM = bm[0][31:0];
        if32.SrcAE = ae[0][31:0];  if32.SrcBE = be[0][31:0];
        if32.Funct3E = f3e;  if32.MulValidE = ve;
        if64.StallW = st;  if64.FlushW = fl;  if64.MulValidM = vm;  if64.Funct3M = f3;
        if64.W64M = w64;   if64.ProdM = ref_prod(64, f3, am[1], bm[1]);
        if64.SrcAM = am[1];  if64.SrcBM = bm[1];  if64.SrcAE = ae[1];  if64.SrcBE = be[1];
        if64.Funct3E = f3e;  if64.MulValidE = ve;
        #1;
        for (int d = 0; d < 2; d++) begin
            xl      = (d == 1) ? 64 : 32;
            exp_hit = FUSE && m_cv[d] && ve && (f3e == 3'b000) && (ae[d] == m_ca[d]) && (be[d] == m_cb[d]);
            exp_res = exp_hit ? xmask(xl, ae[d] * be[d]) : 64'b0;
            obs_hit = (d == 1) ? if64.FuseHitE : if32.FuseHitE;
            obs_res = (d == 1) ? if64.FuseResultE : {32'b0, if32.FuseResultE};
            check($sformatf("fuse_hit%0d", xl), {63'b0, obs_hit}, {63'b0, exp_hit});
            check($sformatf("fuse_res%0d", xl), obs_res, exp_res);
        end
    endtask

    task automatic check_w(input string tag);
        check({tag, "_res32"}, {32'b0, if32.MulResultW}, e_res[0]);
        check({tag, "_vld32"}, {63'b0, if32.MulValidW}, {63'b0, e_vld[0]});
        check({tag, "_res64"}, if64.MulResultW, e_res[1]);
        check({tag, "_vld64"}, {63'b0, if64.MulValidW}, {63'b0, e_vld[1]});
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            e_res[d] = '0;  e_vld[d] = 1'b0;  m_cv[d] = 1'b0;  m_ca[d] = '0;  m_cb[d] = '0;
        end
    endtask

    // One clock edge; inputs are held across it so the model reads the same stimulus.
    task automatic step(input string tag);
        logic wr;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            wr = vm && (f3 >= 3'd1) && (f3 <= 3'd3) && !(d == 1 && w64) && !st && !fl;
            if (fl) begin
                e_res[d] = '0;
                e_vld[d] = 1'b0;
            end else if (!st) begin
                e_res[d] = ref_result((d == 1) ? 64 : 32, f3, w64, am[d], bm[d]);
                e_vld[d] = vm;
            end
            if (wr) begin
                m_cv[d] = 1'b1;  m_ca[d] = am[d];  m_cb[d] = bm[d];
            end
        end
        check_w(tag);
    endtask

    function automatic logic [63:0] rnd(input int d);
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = 64'hFFFF_FFFF_FFFF_FFFF;
            1:       v = 64'h8000_0000_8000_0000;
            2:       v = 64'($urandom_range(0, 7));
            default: v = {$urandom, $urandom};
        endcase
        return (d == 1) ? v : {32'b0, v[31:0]};
    endfunction

    task automatic rand_stim();
        st  = ($urandom_range(0, 4) == 0);
        fl  = ($urandom_range(0, 7) == 0);
        vm  = 1'($urandom_range(0, 1));
        f3  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        w64 = 1'($urandom_range(0, 1));
        ve  = 1'($urandom_range(0, 1));
        f3e = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
        for (int d = 0; d < 2; d++) begin
            am[d] = rnd(d);
            bm[d] = rnd(d);
            if ($urandom_range(0, 1) == 1) begin
                ae[d] = m_ca[d];
                be[d] = ($urandom_range(0, 3) == 0) ? rnd(d) : m_cb[d];
            end else begin
                ae[d] = rnd(d);
                be[d] = rnd(d);
            end
        end
    endtask

    initial begin
        st = 0; fl = 0; vm = 0; w64 = 0; ve = 0; f3 = 0; f3e = 0;
        for (int d = 0; d < 2; d++) begin
            am[d] = '0; bm[d] = '0; ae[d] = '0; be[d] = '0;
        end
        model_reset();
        apply();
        #11;
        check_w("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // MULH of -2*3 on RV32; MULW with a negative low word on RV64
        vm = 1; f3 = 3'b001; w64 = 1;
        am[0] = 64'hFFFF_FFFE; bm[0] = 64'd3; am[1] = 64'h8000_0000; bm[1] = 64'd1;
        apply();
        step("mulh");
        check("mulh_neg_const", {32'b0, if32.MulResultW}, 64'h0000_0000_FFFF_FFFF);
        check("mulw_neg_const", if64.MulResultW, 64'hFFFF_FFFF_8000_0000);
        f3 = 3'b000; am[1] = 64'h7FFF_FFFF;
        apply();
        step("mul");
        check("mul_lo_const", {32'b0, if32.MulResultW}, 64'h0000_0000_FFFF_FFFA);
        check("mulw_pos_const", if64.MulResultW, 64'h0000_0000_7FFF_FFFF);

        // Stall three cycles with changing inputs, then flush together with stall
        w64 = 0; f3 = 3'b011; am[0] = 64'd9; bm[0] = 64'd9; am[1] = 64'd11; bm[1] = 64'd13;
        apply();
        step("pre_stall");
        st = 1;
        for (int i = 0; i < 3; i++) begin
            am[0] = rnd(0); bm[0] = rnd(0); am[1] = rnd(1); bm[1] = rnd(1); vm = ~vm;
            apply();
            step("stall");
        end
        check("stall_hold_const", {32'b0, if32.MulResultW}, 64'd0);
        fl = 1; vm = 1;
        apply();
        step("stall_flush");
        check("flush_vld_const", {63'b0, if32.MulValidW}, 64'd0);

        // Fusion: MULHU 0xFFFFFFFE x 3 fills the cache, then a MUL with equal operands in E
        st = 0; fl = 0; vm = 1; f3 = 3'b011; w64 = 0;
        for (int d = 0; d < 2; d++) begin am[d] = 64'hFFFF_FFFE; bm[d] = 64'd3; end
        apply();
        step("fuse_fill");
        vm = 0; ve = 1; f3e = 3'b000;
        for (int d = 0; d < 2; d++) begin ae[d] = 64'hFFFF_FFFE; be[d] = 64'd3; end
        apply();
        check("fuse_hit_const", {63'b0, if32.FuseHitE}, {63'b0, FUSE});
        check("fuse_res_const", {32'b0, if32.FuseResultE}, FUSE ? 64'hFFFF_FFFA : 64'd0);
        be[0] = 64'd4;
        apply();
        check("fuse_miss_const", {63'b0, if32.FuseHitE}, 64'd0);

        // A flushed high-type op must not refill the cache
        vm = 1; f3 = 3'b001; fl = 1;
        for (int d = 0; d < 2; d++) begin am[d] = 64'd5; bm[d] = 64'd7; end
        apply();
        step("fuse_flush");
        fl = 0; vm = 0;
        for (int d = 0; d < 2; d++) begin ae[d] = 64'd5; be[d] = 64'd7; end
        apply();
        check("fuse_flushed_const", {63'b0, if32.FuseHitE}, 64'd0);
        step("idle");

        for (int i = 0; i < 300; i++) begin
            rand_stim();
            apply();
            step("rand");
        end

        // Asynchronous reset mid-stream, observed before the next clock edge
        vm = 1; f3 = 3'b000; st = 0; fl = 0;
        am[0] = 64'd100; bm[0] = 64'd3; am[1] = 64'd100; bm[1] = 64'd3;
        apply();
        step("pre_reset");
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        check_w("async_reset");
        check("async_hit32", {63'b0, if32.FuseHitE}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        am[0] = 64'd6; bm[0] = 64'd7; am[1] = 64'd6; bm[1] = 64'd7;
        apply();
        step("post_reset");
        check("post_reset_const", {32'b0, if32.MulResultW}, 64'd42);
        check("post_reset_vld", {63'b0, if32.MulValidW}, 64'd1);

        for (int i = 0; i < 200; i++) begin
            rand_stim();
            apply();
            step("rand2");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_result_stage.md
Name: mul_result_stage

Overview:
- Memory/Writeback boundary stage directly downstream of the multiplier.
- Consumes the registered double-width product in M and selects the architectural result per Funct3M: low half, high half, or sign-extended 32-bit result for W ops.
- Registers the result into W with stall/flush, and raises a writeback-valid flag.
- Optional fusion cache holds the last high-half product so a following MUL with equal operands is flagged for early completion.

Parameters:
- XLEN, 32, integer register width; legal values 32 and 64.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- StallW  input  1  hold W register
- FlushW  input  1  clear W register (synchronous)
- MulValidM  input  1  M-stage instruction is a multiply
- Funct3M  input  3  multiply type: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
- W64M  input  1  word op (MULW); ignored when XLEN=32
- ProdM  input  2*XLEN  full product from multiplier M-stage register
- SrcAM, SrcBM  input  XLEN  M-stage operands (used only with fusion)
- SrcAE, SrcBE  input  XLEN  E-stage operands (used only with fusion)
- Funct3E  input  3  E-stage multiply type (used only with fusion)
- MulValidE  input  1  E-stage instruction is a multiply (used only with fusion)
- MulResultW  output  XLEN  selected result in W
- MulValidW  output  1  W result valid
- FuseHitE  output  1  E-stage MUL matches cached product (0 without fusion)
- FuseResultE  output  XLEN  cached low half for FuseHitE (0 without fusion)

Behaviour:
- Reset (reset_n low, async): MulResultW=0, MulValidW=0, fusion cache valid=0, FuseHitE=0, FuseResultE=0. Reset asserted mid-operation discards all state immediately.
- Select (combinational, M):
  - Funct3M 000 → ProdM[XLEN-1:0].
  - Funct3M 001/010/011 → ProdM[2*XLEN-1:XLEN].
  - Funct3M 1xx → 0. Not expected; must not cause X or a latch.
- W op (XLEN=64, W64M=1): result = sign-extend ProdM[31:0] to 64 bits, regardless of Funct3M.
- W register, 1-cycle latency, updates on clk rising edge:
  - FlushW=1 → MulResultW=0, MulValidW=0. Flush wins over stall.
  - Else StallW=1 → hold both outputs.
  - Else → load selected result; MulValidW=MulValidM.
  - MulResultW loads even when MulValidM=0; it is meaningful only when MulValidW=1.
- Back-to-back ops with no stall produce one result per cycle, in order.

Optional Feature:
- Macro: MUL_RESULT_STAGE_FUSE_EN.
- Defined:
  - One-entry cache {valid, A, B, ProdLo}.
  - Written on the clock edge where MulValidM=1, Funct3M∈{001,010,011}, W64M=0, StallW=0 and FlushW=0. Stores SrcAM, SrcBM, ProdM[XLEN-1:0]. The low half is signedness-independent, so any high-type op qualifies.
  - FuseHitE = valid & MulValidE & Funct3E==000 & SrcAE==A & SrcBE==B (combinational).
  - FuseResultE = ProdLo when FuseHitE=1, else 0.
  - A cache write and an E-stage lookup in the same cycle use the old entry; the new entry is visible next cycle.
  - Cache is not invalidated by FlushW; its contents are a pure function of the operands.
- Undefined: no cache storage; FuseHitE and FuseResultE tied to 0; SrcAM, SrcBM, SrcAE, SrcBE, Funct3E and MulValidE unused.

Test Plan:
- XLEN=32, ProdM=0xFFFFFFFF_FFFFFFFA (-2*3 signed), Funct3M=001, valid → next cycle MulResultW=0xFFFFFFFF, MulValidW=1. Same ProdM with Funct3M=000 → 0xFFFFFFFA.
- XLEN=64, W64M=1, ProdM low word 0x80000000 → MulResultW=0xFFFFFFFF_80000000. Low word 0x7FFFFFFF → 0x00000000_7FFFFFFF.
- StallW held 3 cycles while ProdM changes → MulResultW and MulValidW unchanged. FlushW together with StallW → both cleared next edge.
- reset_n pulsed low mid-stream → outputs 0 asynchronously, before the next clk edge. After release, first result appears 1 cycle after its M cycle.
- FUSE_EN: MULHU 0xFFFFFFFE×3 in M (ProdM=0x2_FFFFFFFA), then MUL with same operands in E → FuseHitE=1, FuseResultE=0xFFFFFFFA. Change SrcBE to 4 → FuseHitE=0.
- FUSE_EN: high-type op in M flushed by FlushW → cache not written; subsequent matching MUL gives FuseHitE=0.
